// File: rtl/control_fsm.sv
// Instruction register, decoder and multi-cycle control FSM for the 16-bit CPU.
// Control outputs are decoded combinationally from the current state and the latched IR.
module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic [7:0]  flags_in,
  output logic [15:0] reg_en,
  output logic [4:0]  sel_a,
  output logic [4:0]  sel_b,
  output logic        imm_sel,
  output logic [15:0] imm_out,
  output logic [7:0]  alu_op,
  output logic        bus_en,
  output logic        flag_en,
  output logic        pc_en,
  output logic        pc_sel,
  output logic [15:0] pc_disp,
  output logic        mem_we,
  output logic        ld_wb_sel,
  output logic        halted,
  output logic [2:0]  state_out
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_LD_RD  = 3'd3;
  localparam logic [2:0] S_LD_WB  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_BR    = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [3:0] op, rd, opext, rs;
  logic [7:0] imm8;

  assign op    = ir_q[15:12];
  assign rd    = ir_q[11:8];
  assign opext = ir_q[7:4];
  assign rs    = ir_q[3:0];
  assign imm8  = ir_q[7:0];

  logic unused_flags;
  assign unused_flags = ^{flags_in[7:5], flags_in[2:1]};

  // Codes shared by R-type opext and immediate-form op.
  function automatic logic is_alu_code(input logic [3:0] c);
    case (c)
      4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101: is_alu_code = 1'b1;
      default: is_alu_code = 1'b0;
    endcase
  endfunction

  function automatic logic br_taken(input logic [3:0] cond, input logic [7:0] f);
    case (cond)
      4'b0000: br_taken = f[3];
      4'b0001: br_taken = ~f[3];
      4'b0010: br_taken = f[0];
      4'b0011: br_taken = ~f[0];
      4'b0110: br_taken = f[4];
      4'b0111: br_taken = ~f[4];
      4'b1110: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state, IR capture and control decode.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    reg_en    = 16'h0000;
    sel_a     = 5'd0;
    sel_b     = 5'd0;
    imm_sel   = 1'b0;
    imm_out   = 16'h0000;
    alu_op    = 8'h00;
    bus_en    = 1'b0;
    flag_en   = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    pc_disp   = 16'h0000;
    mem_we    = 1'b0;
    ld_wb_sel = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        ir_d = instr_in;
        if (instr_in[15:12] == OP_HALT)
          state_d = S_HALT;
        else if (instr_in[15:12] == OP_MEM && instr_in[7:4] == EXT_LOAD)
          state_d = S_LD_RD;
        else
          state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        pc_en   = 1'b1;
        if (op == OP_RTYPE && is_alu_code(opext)) begin
          sel_a   = {1'b0, rd};
          sel_b   = {1'b0, rs};
          alu_op  = {4'b0000, opext};
          flag_en = 1'b1;
          if (opext != OP_CMP) begin
            bus_en = 1'b1;
            reg_en = 16'h0001 << rd;
          end
        end else if (is_alu_code(op)) begin
          sel_a   = {1'b0, rd};
          imm_sel = 1'b1;
          alu_op  = {4'b0000, op};
          flag_en = 1'b1;
          // ADDI/SUBI/CMPI sign-extend; logical and move forms zero-extend.
          if (op == 4'b0101 || op == 4'b1001 || op == OP_CMP)
            imm_out = {{8{imm8[7]}}, imm8};
          else
            imm_out = {8'h00, imm8};
          if (op != OP_CMP) begin
            bus_en = 1'b1;
            reg_en = 16'h0001 << rd;
          end
        end else if (op == OP_MEM && opext == EXT_STOR) begin
          sel_a  = {1'b0, rd};
          sel_b  = {1'b0, rs};
          mem_we = 1'b1;
        end else if (op == OP_BR) begin
          pc_sel  = br_taken(rd, flags_in);
          pc_disp = {{8{imm8[7]}}, imm8};
        end
      end

      S_LD_RD: begin
        state_d = S_LD_WB;
        sel_b   = {1'b0, rs};
      end

      S_LD_WB: begin
        state_d   = S_FETCH;
        ld_wb_sel = 1'b1;
        reg_en    = 16'h0001 << rd;
        pc_en     = 1'b1;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Table-driven bench for control_fsm: expected final-state controls are queued
// when an instruction is driven and compared when the DUT raises pc_en.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic [7:0]  flags_in;
  logic [15:0] reg_en;
  logic [4:0]  sel_a, sel_b;
  logic        imm_sel;
  logic [15:0] imm_out;
  logic [7:0]  alu_op;
  logic        bus_en, flag_en, pc_en, pc_sel;
  logic [15:0] pc_disp;
  logic        mem_we, ld_wb_sel, halted;
  logic [2:0]  state_out;

  control_fsm dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .flags_in(flags_in),
    .reg_en(reg_en), .sel_a(sel_a), .sel_b(sel_b), .imm_sel(imm_sel),
    .imm_out(imm_out), .alu_op(alu_op), .bus_en(bus_en), .flag_en(flag_en),
    .pc_en(pc_en), .pc_sel(pc_sel), .pc_disp(pc_disp), .mem_we(mem_we),
    .ld_wb_sel(ld_wb_sel), .halted(halted), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  flags;
    logic [15:0] reg_en;
    logic [4:0]  sel_a;
    logic [4:0]  sel_b;
    logic        imm_sel;
    logic [15:0] imm_out;
    logic [7:0]  alu_op;
    logic        bus_en;
    logic        flag_en;
    logic        pc_sel;
    logic [15:0] pc_disp;
    logic        mem_we;
    logic        ld_wb;
    logic [3:0]  cycles;
  } vec_t;

  localparam int unsigned NVEC = 22;
  vec_t vecs [NVEC];
  vec_t sb_q [$];

  int n_vec  = 0;
  int n_fail = 0;

  function automatic vec_t mk(
    input logic [15:0] instr, input logic [7:0] flags, input logic [15:0] re,
    input logic [4:0] sa, input logic [4:0] sb, input logic isel,
    input logic [15:0] imm, input logic [7:0] alu, input logic bus,
    input logic fl, input logic psel, input logic [15:0] disp,
    input logic we, input logic ld, input logic [3:0] cyc);
    vec_t v;
    v = '{instr, flags, re, sa, sb, isel, imm, alu, bus, fl, psel, disp, we, ld, cyc};
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Starts at a FETCH-cycle negedge, ends at the next FETCH-cycle negedge.
  task automatic run_instr(input vec_t v);
    vec_t e;
    int   cyc;
    instr_in = v.instr;
    flags_in = v.flags;
    sb_q.push_back(v);
    cyc = 1;
    while (pc_en !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    if (pc_en !== 1'b1) begin
      check("pc_en_timeout", 16'(pc_en), 16'h0001);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      check($sformatf("%04h cycles", e.instr), 16'(cyc), 16'(e.cycles));
      check($sformatf("%04h state", e.instr), 16'(state_out), (e.cycles == 4'd4) ? 16'd4 : 16'd2);
      check($sformatf("%04h reg_en", e.instr), reg_en, e.reg_en);
      check($sformatf("%04h sel_a", e.instr), 16'(sel_a), 16'(e.sel_a));
      check($sformatf("%04h sel_b", e.instr), 16'(sel_b), 16'(e.sel_b));
      check($sformatf("%04h imm_sel", e.instr), 16'(imm_sel), 16'(e.imm_sel));
      check($sformatf("%04h imm_out", e.instr), imm_out, e.imm_out);
      check($sformatf("%04h alu_op", e.instr), 16'(alu_op), 16'(e.alu_op));
      check($sformatf("%04h bus_en", e.instr), 16'(bus_en), 16'(e.bus_en));
      check($sformatf("%04h flag_en", e.instr), 16'(flag_en), 16'(e.flag_en));
      check($sformatf("%04h pc_sel", e.instr), 16'(pc_sel), 16'(e.pc_sel));
      check($sformatf("%04h pc_disp", e.instr), pc_disp, e.pc_disp);
      check($sformatf("%04h mem_we", e.instr), 16'(mem_we), 16'(e.mem_we));
      check($sformatf("%04h ld_wb_sel", e.instr), 16'(ld_wb_sel), 16'(e.ld_wb));
      check($sformatf("%04h halted", e.instr), 16'(halted), 16'h0000);
    end
    @(negedge clk);
  endtask

  initial begin
    int strobes;
    //            instr     flags  reg_en    sa  sb  is  imm       alu    bu fl ps disp      we ld cyc
    vecs[0]  = mk(16'h0351, 8'h00, 16'h0008, 3,  1,  0, 16'h0000, 8'h05, 1, 1, 0, 16'h0000, 0, 0, 3);
    vecs[1]  = mk(16'h52FF, 8'h00, 16'h0004, 2,  0,  1, 16'hFFFF, 8'h05, 1, 1, 0, 16'h0000, 0, 0, 3);
    vecs[2]  = mk(16'h12FF, 8'h00, 16'h0004, 2,  0,  1, 16'h00FF, 8'h01, 1, 1, 0, 16'h0000, 0, 0, 3);
    vecs[3]  = mk(16'hC0FE, 8'h08, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 1, 16'hFFFE, 0, 0, 3);
    vecs[4]  = mk(16'hC0FE, 8'h00, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 0, 16'hFFFE, 0, 0, 3);
    vecs[5]  = mk(16'h4402, 8'h00, 16'h0010, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 4);
    vecs[6]  = mk(16'h4542, 8'h00, 16'h0000, 5,  2,  0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 3);
    vecs[7]  = mk(16'h0BB3, 8'h00, 16'h0000, 11, 3,  0, 16'h0000, 8'h0B, 0, 1, 0, 16'h0000, 0, 0, 3);
    vecs[8]  = mk(16'hB780, 8'h00, 16'h0000, 7,  0,  1, 16'hFF80, 8'h0B, 0, 1, 0, 16'h0000, 0, 0, 3);
    vecs[9]  = mk(16'h0070, 8'h00, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 0, 0, 3);
    vecs[10] = mk(16'h7123, 8'h00, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 0, 0, 3);
    vecs[11] = mk(16'hCE05, 8'h00, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 1, 16'h0005, 0, 0, 3);
    vecs[12] = mk(16'hC280, 8'h01, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 1, 16'hFF80, 0, 0, 3);
    vecs[13] = mk(16'hC401, 8'hFF, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 0, 16'h0001, 0, 0, 3);
    vecs[14] = mk(16'hD0AB, 8'h00, 16'h0001, 0,  0,  1, 16'h00AB, 8'h0D, 1, 1, 0, 16'h0000, 0, 0, 3);
    vecs[15] = mk(16'h0F32, 8'h00, 16'h8000, 15, 2,  0, 16'h0000, 8'h03, 1, 1, 0, 16'h0000, 0, 0, 3);
    vecs[16] = mk(16'hC710, 8'h10, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 0, 16'h0010, 0, 0, 3);
    vecs[17] = mk(16'hC6F0, 8'h10, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 1, 16'hFFF0, 0, 0, 3);
    vecs[18] = mk(16'h0000, 8'h00, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 0, 0, 3);
    vecs[19] = mk(16'h4012, 8'h00, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 0, 0, 3);
    vecs[20] = mk(16'hC103, 8'h00, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 1, 16'h0003, 0, 0, 3);
    vecs[21] = mk(16'hC3FF, 8'h01, 16'h0000, 0,  0,  0, 16'h0000, 8'h00, 0, 0, 0, 16'hFFFF, 0, 0, 3);

    reset    = 1'b1;
    instr_in = 16'h0000;
    flags_in = 8'h00;
    @(negedge clk);
    check("rst state", 16'(state_out), 16'd0);
    check("rst reg_en", reg_en, 16'h0000);
    check("rst pc_en", 16'(pc_en), 16'h0000);
    check("rst halted", 16'(halted), 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) run_instr(vecs[i]);

    // LOAD: LD_RD drives the address select with no strobes.
    instr_in = 16'h4402;
    @(negedge clk);
    @(negedge clk);
    check("ld_rd state", 16'(state_out), 16'd3);
    check("ld_rd sel_b", 16'(sel_b), 16'd2);
    check("ld_rd strobes", {reg_en[14:0], pc_en}, 16'h0000);
    @(negedge clk);
    @(negedge clk);

    // Reset asserted mid-EXEC of ADD drops strobes at once.
    instr_in = 16'h0351;
    @(negedge clk);
    @(negedge clk);
    check("mid exec reg_en", reg_en, 16'h0008);
    #1 reset = 1'b1;
    #1;
    check("mid rst reg_en", reg_en, 16'h0000);
    check("mid rst state", 16'(state_out), 16'd0);
    check("mid rst pc_en", 16'(pc_en), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("resume decode", 16'(state_out), 16'd1);
    @(negedge clk);
    check("resume exec", 16'(state_out), 16'd2);
    @(negedge clk);

    // HALT holds with no strobes until reset.
    instr_in = 16'hF000;
    @(negedge clk);
    @(negedge clk);
    check("halt state", 16'(state_out), 16'd5);
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      if (pc_en || mem_we || reg_en != 16'h0000 || !halted) strobes++;
      @(negedge clk);
    end
    check("halt hold", 16'(strobes), 16'h0000);
    check("halt state hold", 16'(state_out), 16'd5);
    #1 reset = 1'b1;
    #1;
    check("halt rst halted", 16'(halted), 16'h0000);
    check("halt rst state", 16'(state_out), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    run_instr(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Instruction register, decoder and multi-cycle control state machine for the 16-bit CPU. It sits directly upstream of the ALU datapath. It latches the instruction word fetched from BRAM port A and drives every datapath control: register-file write enables, operand mux selects, immediate mux, ALU opcode, bus tristate, flag write, program-counter update and BRAM port-B load/store strobes. Each instruction executes in 3 or 4 cycles.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instr_in`  in  16  BRAM port-A read data, bits [15:0]; valid during DECODE.
- `flags_in`  in  8  flag register contents: [0] C, [1] L, [2] F, [3] Z, [4] N.
- `reg_en`  out  16  one-hot register-file write enable.
- `sel_a`  out  5  mux1 select (Rdest index, zero-extended).
- `sel_b`  out  5  mux2 select (Rsrc index, zero-extended).
- `imm_sel`  out  1  1 selects `imm_out` over mux2 for ALU operand B.
- `imm_out`  out  16  extended immediate.
- `alu_op`  out  8  ALU opcode, {4'b0000, op code}.
- `bus_en`  out  1  ALU result tristate enable.
- `flag_en`  out  1  flag register write enable.
- `pc_en`  out  1  single-cycle PC load strobe.
- `pc_sel`  out  1  1 selects PC + `pc_disp`; 0 selects PC + 1.
- `pc_disp`  out  16  sign-extended branch displacement.
- `mem_we`  out  1  BRAM port-B write (store).
- `ld_wb_sel`  out  1  1 steers BRAM port-B read data onto the register write-back bus.
- `halted`  out  1  high in HALT.
- `state_out`  out  3  current state encoding, for debug.

## Operation
- **Instruction format:** [15:12] op, [11:8] Rdest, [7:4] opext, [3:0] Rsrc. Immediate forms use [7:0] imm.
- **R-type (op 0000):** opext selects the operation:
  - 0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV.
  - `alu_op` = {4'b0, opext}.
  - opext 0000 is NOP.
  - Any other opext is a NOP.
- **Immediate forms:** op 0101/1001/1011/0001/0010/0011/1101 give ADDI/SUBI/CMPI/ANDI/ORI/XORI/MOVI.
  - `alu_op` = {4'b0, op}.
  - ADDI/SUBI/CMPI sign-extend imm; the rest zero-extend.
- **Memory (op 0100):**
  - opext 0000 LOAD Rdest ← mem[Rsrc].
  - opext 0100 STOR mem[Rsrc] ← Rdest.
  - Address comes from the mux2 output and store data from mux1; `sel_a`=Rdest, `sel_b`=Rsrc.
- **Branch (op 1100):** [11:8] cond, [7:0] signed displacement.
  - Conditions: 0000 EQ (Z=1), 0001 NE (Z=0), 0010 CS (C=1), 0011 CC (C=0), 0110 GT (N=1), 0111 LE (N=0), 1110 UC (always).
  - Any other cond is never taken.
- **HALT:** op 1111.
- **Undefined:** any other op executes as a NOP.
- **States:** FETCH=0, DECODE=1, EXEC=2, LD_RD=3, LD_WB=4, HALT=5.
  - FETCH → DECODE always. BRAM registers the word at the PC address.
  - DECODE → next state; IR ← `instr_in` on the exit edge.
    - LOAD goes to LD_RD.
    - HALT goes to HALT.
    - Everything else goes to EXEC.
  - EXEC → FETCH.
  - LD_RD → LD_WB → FETCH.
  - HALT holds until reset.
- **Outputs:** all control outputs are combinational from state and IR. Every output not listed for a state is 0.
- **EXEC, ALU write ops:** `sel_a`, `sel_b`/`imm_sel`, `alu_op`; `bus_en`=1; `reg_en`=1<<Rdest; `flag_en`=1; `pc_en`=1, `pc_sel`=0.
- **EXEC, CMP/CMPI:** same, except `bus_en`=0 and `reg_en`=0.
- **EXEC, STOR:** `mem_we`=1, `pc_en`=1.
- **EXEC, branch:** `pc_en`=1, `pc_sel`=taken, `pc_disp`=sext(disp). `flags_in` is sampled combinationally in EXEC.
- **EXEC, NOP/undefined:** `pc_en`=1 only.
- **LD_RD:** `sel_b`=Rsrc. The BRAM read is in flight.
- **LD_WB:** `ld_wb_sel`=1, `reg_en`=1<<Rdest, `pc_en`=1.
- **HALT:** `halted`=1; no strobes.

## Timing
- **Reset:** state=FETCH, IR=0, every output 0, `halted`=0.
- **Reset mid-instruction:** strobes drop immediately (asynchronous). No partial register or memory write survives past the reset edge.
- **Latency:** ALU, CMP, STOR, branch and NOP take 3 cycles. LOAD takes 4 cycles.
- **`pc_en`:** high for exactly one cycle per instruction, in its final state. The new PC is visible in the following FETCH.
- **Displacement:** 8-bit, sign-extended to 16 bits. Wrap-around follows the PC width, with no saturation.
- **R0:** writes to R0 are permitted; R0 is not hardwired.
- **Flags:** a branch immediately after CMP sees the updated flags, because the flag register updates on the CMP EXEC exit edge.

## Test plan
- Reset asserted mid-EXEC of ADD with `reg_en`=0x0008 → `reg_en`=0, `state_out`=0 within the same cycle. After release, FETCH→DECODE→EXEC resumes.
- `instr_in`=0x0351 (ADD R3,R1) → EXEC: `reg_en`=0x0008, `sel_a`=3, `sel_b`=1, `alu_op`=0x05, `bus_en`=1, `flag_en`=1, `pc_en`=1, `pc_sel`=0. 3 cycles total.
- `instr_in`=0x52FF (ADDI R2,-1) → `imm_sel`=1, `imm_out`=0xFFFF. `instr_in`=0x12FF (ANDI) → `imm_out`=0x00FF.
- `instr_in`=0xC0FE (BEQ -2) with `flags_in`=0x08 → `pc_sel`=1, `pc_disp`=0xFFFE. With `flags_in`=0x00 → `pc_sel`=0.
- `instr_in`=0x4402 (LOAD R4,[R2]) → 4 cycles. LD_WB: `ld_wb_sel`=1, `reg_en`=0x0010, `pc_en`=1. `instr_in`=0x4542 (STOR) → EXEC `mem_we`=1.
- `instr_in`=0xF000 → `halted`=1 and no `pc_en` for 20 cycles. Reset → `halted`=0, FETCH.
